// File: rtl/rx_link_fault_detect.sv
// XGMII receive link fault detector: classifies local/remote fault
// ordered sets per column and runs the link fault state machine.
module rx_link_fault_detect #(
  parameter int SEQ_THRESH = 4,
  parameter int COL_THRESH = 128,
  parameter int COL_W      = 8
) (
  input  logic        rxclk,
  input  logic        reset,
  input  logic [63:0] rxd64,
  input  logic [7:0]  rxc8,
  output logic [1:0]  link_fault,
  output logic [1:0]  seq_detect,
  output logic        fault_change
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    COUNT = 2'd1,
    FAULT = 2'd2
  } state_t;

  typedef enum logic {
    LOCAL  = 1'b0,
    REMOTE = 1'b1
  } ftype_t;

  typedef struct packed {
    state_t           st;
    logic [2:0]       seq;
    logic [COL_W-1:0] col;
    ftype_t           last;
    logic [1:0]       lf;
  } ctx_t;

  // Returns {local, remote} for one 4-lane column.
  function automatic logic [1:0] classify(
    input logic [31:0] d,
    input logic [3:0]  c
  );
    logic hdr;
    hdr = (c == 4'b0001) && (d[7:0] == 8'h9C) &&
          (d[15:8] == 8'h00) && (d[23:16] == 8'h00);
    return {hdr && (d[31:24] == 8'h01),
            hdr && (d[31:24] == 8'h02)};
  endfunction

  function automatic ctx_t step(
    input ctx_t       s,
    input logic [1:0] cls
  );
    ctx_t             n;
    logic             hit;
    ftype_t           t;
    logic [2:0]       seq_inc;
    logic [COL_W-1:0] col_inc;
    n       = s;
    hit     = |cls;
    t       = cls[0] ? REMOTE : LOCAL;
    seq_inc = (s.seq >= 3'(SEQ_THRESH)) ?
              s.seq : s.seq + 3'd1;
    col_inc = (&s.col) ? s.col : s.col + COL_W'(1);
    unique case (s.st)
      INIT: begin
        if (hit) begin
          n.st   = COUNT;
          n.last = t;
          n.seq  = 3'd1;
          n.col  = '0;
        end
      end
      COUNT: begin
        if (hit && t == s.last) begin
          n.seq = seq_inc;
          n.col = '0;
          if (seq_inc >= 3'(SEQ_THRESH)) begin
            n.st = FAULT;
            n.lf = {1'b1, t == REMOTE};
          end
        end else if (hit) begin
          // Held fault stays visible until the new type is confirmed.
          n.last = t;
          n.seq  = 3'd1;
          n.col  = '0;
        end else begin
          n.col = col_inc;
          if (col_inc >= COL_W'(COL_THRESH)) begin
            n.st  = INIT;
            n.seq = '0;
            n.col = '0;
            n.lf  = 2'b00;
          end
        end
      end
      FAULT: begin
        if (hit && t == s.last) begin
          n.col = '0;
        end else if (hit) begin
          n.st   = COUNT;
          n.last = t;
          n.seq  = 3'd1;
          n.col  = '0;
        end else begin
          n.col = col_inc;
          if (col_inc >= COL_W'(COL_THRESH)) begin
            n.st  = INIT;
            n.seq = '0;
            n.col = '0;
            n.lf  = 2'b00;
          end
        end
      end
      default: begin
        n.st  = INIT;
        n.seq = '0;
        n.col = '0;
        n.lf  = 2'b00;
      end
    endcase
    return n;
  endfunction

  ctx_t       cur;
  ctx_t       mid;
  ctx_t       nxt;
  logic [1:0] cls_lo;
  logic [1:0] cls_hi;

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      cur.st       <= INIT;
      cur.seq      <= '0;
      cur.col      <= '0;
      cur.last     <= LOCAL;
      cur.lf       <= 2'b00;
      seq_detect   <= 2'b00;
      fault_change <= 1'b0;
    end else begin
      cur          <= nxt;
      seq_detect   <= cls_lo | cls_hi;
      fault_change <= (nxt.lf != cur.lf);
    end
  end

  // Low column first; its result seeds the high column.
  always_comb begin
    cls_lo = classify(rxd64[31:0], rxc8[3:0]);
    cls_hi = classify(rxd64[63:32], rxc8[7:4]);
    mid    = step(cur, cls_lo);
    nxt    = step(mid, cls_hi);
  end

  assign link_fault = cur.lf;

endmodule

// File: tb/tb_rx_link_fault_detect.sv
// Scoreboard bench for rx_link_fault_detect: directed column
// vectors with hand-computed per-cycle expectations.
module tb_rx_link_fault_detect;

  logic        rxclk = 1'b0;
  logic        reset;
  logic [63:0] rxd64;
  logic [7:0]  rxc8;
  logic [1:0]  link_fault;
  logic [1:0]  seq_detect;
  logic        fault_change;

  rx_link_fault_detect dut (
    .rxclk        (rxclk),
    .reset        (reset),
    .rxd64        (rxd64),
    .rxc8         (rxc8),
    .link_fault   (link_fault),
    .seq_detect   (seq_detect),
    .fault_change (fault_change)
  );

  always #5 rxclk = ~rxclk;

  localparam logic [35:0] LOC  = {4'b0001, 32'h0100009C};
  localparam logic [35:0] REM  = {4'b0001, 32'h0200009C};
  localparam logic [35:0] IDL  = {4'b1111, 32'h07070707};
  localparam logic [35:0] BAD  = {4'b0001, 32'h0300009C};
  localparam logic [35:0] BADC = {4'b0011, 32'h0100009C};

  typedef struct {
    string      tag;
    logic [1:0] lf;
    logic [1:0] sd;
    logic       fc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [35:0] lo, input logic [35:0] hi,
                     input string tag, input logic [1:0] lf,
                     input logic [1:0] sd, input logic fc);
    exp_t e;
    @(negedge rxclk);
    rxd64 = {hi[31:0], lo[31:0]};
    rxc8  = {hi[35:32], lo[35:32]};
    e.tag = tag;
    e.lf  = lf;
    e.sd  = sd;
    e.fc  = fc;
    q.push_back(e);
  endtask

  task automatic run(input int n, input logic [35:0] lo,
                     input logic [35:0] hi, input string tag,
                     input logic [1:0] lf, input logic [1:0] sd,
                     input logic fc);
    for (int i = 0; i < n; i++) cyc(lo, hi, tag, lf, sd, fc);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".lf"}, 32'(link_fault), 32'd0);
    chk({tag, ".sd"}, 32'(seq_detect), 32'd0);
    chk({tag, ".fc"}, 32'(fault_change), 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge rxclk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, ".lf"}, 32'(link_fault), 32'(e.lf));
        chk({e.tag, ".sd"}, 32'(seq_detect), 32'(e.sd));
        chk({e.tag, ".fc"}, 32'(fault_change), 32'(e.fc));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1;
    rxd64 = {IDL[31:0], IDL[31:0]};
    rxc8  = {IDL[35:32], IDL[35:32]};
    repeat (2) @(posedge rxclk);
    @(negedge rxclk);
    reset = 1'b0;
    chk_zero("rst");

    // Three local sequences only: no fault yet.
    run(3, LOC, IDL, "loc3", 2'b00, 2'b10, 1'b0);

    // Asynchronous reset mid-COUNT.
    @(negedge rxclk);
    #2;
    rxd64 = {IDL[31:0], IDL[31:0]};
    rxc8  = {IDL[35:32], IDL[35:32]};
    reset = 1'b1;
    #1;
    chk_zero("arst");
    @(negedge rxclk);
    reset = 1'b0;

    // Count restarts: four local columns needed again.
    run(3, LOC, IDL, "loc_after_rst", 2'b00, 2'b10, 1'b0);
    cyc(LOC, IDL, "loc4", 2'b10, 2'b10, 1'b1);

    // Remote takes over only after four remote columns.
    run(3, REM, IDL, "rem3", 2'b10, 2'b01, 1'b0);
    cyc(REM, IDL, "rem4", 2'b11, 2'b01, 1'b1);

    // col_cnt is 1 here; 64 idle cycles reach 128.
    run(63, IDL, IDL, "rem_hold", 2'b11, 2'b00, 1'b0);
    cyc(IDL, IDL, "rem_clear", 2'b00, 2'b00, 1'b1);

    // Both columns local: fault after the second cycle, col_cnt=0.
    cyc(LOC, LOC, "dual1", 2'b00, 2'b10, 1'b0);
    cyc(LOC, LOC, "dual2", 2'b10, 2'b10, 1'b1);
    run(63, IDL, IDL, "hold126", 2'b10, 2'b00, 1'b0);
    cyc(IDL, IDL, "clr128", 2'b00, 2'b00, 1'b1);

    // High-column-only remote pattern.
    cyc(IDL, REM, "hi_rem", 2'b00, 2'b01, 1'b0);
    // Type change to local: seq=2 after this cycle.
    cyc(LOC, LOC, "sw_loc", 2'b00, 2'b10, 1'b0);
    // 126 idle columns do not clear the count.
    run(63, IDL, IDL, "cnt126", 2'b00, 2'b00, 1'b0);
    cyc(LOC, LOC, "cnt_fault", 2'b10, 2'b10, 1'b1);
    run(63, IDL, IDL, "hold2", 2'b10, 2'b00, 1'b0);
    cyc(IDL, IDL, "clr2", 2'b00, 2'b00, 1'b1);

    // 2 local, 128 idle columns, 2 local: count was cleared.
    cyc(LOC, LOC, "pre2", 2'b00, 2'b10, 1'b0);
    run(64, IDL, IDL, "gap128", 2'b00, 2'b00, 1'b0);
    cyc(LOC, LOC, "post2", 2'b00, 2'b10, 1'b0);

    // Near-miss patterns are never counted.
    run(3, BAD, BAD, "lane3_03", 2'b00, 2'b00, 1'b0);
    run(2, BADC, BADC, "bad_rxc", 2'b00, 2'b00, 1'b0);
    cyc(IDL, IDL, "tail", 2'b00, 2'b00, 1'b0);

    repeat (3) @(negedge rxclk);
    chk("drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
